// File: rtl/dma_ctrl.sv
// dma_ctrl: word-at-a-time DMA between DRAM req/ack port and SRAM port, stalling the core while busy.
module dma_ctrl #(
  parameter int WORD_BYTES = 4,
  parameter int WIDTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            cmd,
  input  logic [31:0]           srcAddress,
  input  logic [31:0]           dstAddress,
  input  logic [WIDTH_BITS-1:0] width,
  output logic                  stall,
  output logic                  valid,
  output logic                  sramOwn,
  output logic [31:0]           sramAddr,
  output logic                  sramWriteEnable,
  output logic [31:0]           sramWriteData,
  input  logic [31:0]           sramReadData,
  output logic [31:0]           dramAddr,
  output logic                  dramReadReq,
  output logic                  dramWriteReq,
  output logic [31:0]           dramWriteData,
  input  logic [31:0]           dramReadData,
  input  logic                  dramAck
);
  typedef enum logic [2:0] {IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_WR, DONE} state_t;
  localparam logic [31:0] INC = 32'(WORD_BYTES);
  localparam logic [WIDTH_BITS-1:0] ONE = 1;
  state_t state, state_nx;
  logic [31:0] src, dst, data;
  logic [WIDTH_BITS-1:0] count;
  logic accept, step, last;
  assign accept = (state == IDLE) && (cmd == 2'b01 || cmd == 2'b10);
  assign step = (state == D2S_WR) || (state == S2D_WR && dramAck);
  assign last = (count == ONE);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : (width == '0) ? DONE : (cmd == 2'b01) ? D2S_RD : S2D_RD;
      D2S_RD:  state_nx = dramAck ? D2S_WR : D2S_RD;
      D2S_WR:  state_nx = last ? DONE : D2S_RD;
      S2D_RD:  state_nx = S2D_WR;
      S2D_WR:  state_nx = !dramAck ? S2D_WR : last ? DONE : S2D_RD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      data  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        src   <= srcAddress;
        dst   <= dstAddress;
        count <= width;
      end
      if (state == D2S_RD && dramAck) data <= dramReadData;
      if (state == S2D_RD) data <= sramReadData;
      if (step) begin
        src   <= src + INC;
        dst   <= dst + INC;
        count <= count - ONE;
      end
    end
  end
  // Every output is a decode of the state flop, so stall is registered and reset clears all at once.
  assign stall           = (state != IDLE) && (state != DONE);
  assign sramOwn         = stall;
  assign valid           = (state == DONE);
  assign dramReadReq     = (state == D2S_RD);
  assign dramWriteReq    = (state == S2D_WR);
  assign sramWriteEnable = (state == D2S_WR);
  assign dramAddr        = dramReadReq ? src : dramWriteReq ? dst : '0;
  assign sramAddr        = sramWriteEnable ? dst : (state == S2D_RD) ? src : '0;
  assign sramWriteData   = sramWriteEnable ? data : '0;
  assign dramWriteData   = dramWriteReq ? data : '0;
endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- DMA engine directly downstream of the single-cycle MIPS core.
- Consumes the core's decoded DMA command (d2s = DRAM→SRAM, s2d = SRAM→DRAM), source/destination addresses and word count.
- Moves data one 32-bit word at a time between the DRAM request/ack port and the SRAM port, holding the core in stall while busy, then pulses valid on completion.
- Owns the SRAM port while busy; the top level muxes SRAM between core and DMA using sramOwn.

Parameters:
- WORD_BYTES, 4, byte address increment applied to both addresses after each word
- WIDTH_BITS, 10, width of the word-count field

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- cmd  input  2  00 none, 01 d2s, 10 s2d, 11 reserved (ignored)
- srcAddress  input  32  byte address of first source word
- dstAddress  input  32  byte address of first destination word
- width  input  WIDTH_BITS  number of 32-bit words to move
- stall  output  1  core hold request
- valid  output  1  one-cycle completion pulse
- sramOwn  output  1  DMA owns SRAM port
- sramAddr  output  32  SRAM byte address
- sramWriteEnable  output  1  SRAM write strobe
- sramWriteData  output  32  SRAM write data
- sramReadData  input  32  SRAM read data (combinational read)
- dramAddr  output  32  DRAM byte address
- dramReadReq  output  1  DRAM read request
- dramWriteReq  output  1  DRAM write request
- dramWriteData  output  32  DRAM write data
- dramReadData  input  32  DRAM read data, valid while dramAck=1
- dramAck  input  1  DRAM completes the current request this cycle

Behaviour:
- Reset (async) forces state IDLE; all outputs 0; internal address/count/data registers cleared. Reset mid-transfer aborts with no valid pulse.
- States: IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_WR, DONE.
- IDLE:
  - cmd=01 or 10 sampled at the clock edge latches srcAddress, dstAddress, width and direction.
  - Next state is D2S_RD or S2D_RD, or DONE if width=0.
  - cmd=11 or 00: stay in IDLE.
- Commands arriving in any state other than IDLE are ignored (the core drives cmd=0 while stalled).
- D2S_RD:
  - dramReadReq=1, dramAddr=src; held stable until dramAck.
  - On an ack cycle, capture dramReadData and go to D2S_WR.
  - An ack may arrive in the first cycle of the request.
- D2S_WR:
  - sramWriteEnable=1 for exactly one cycle; sramAddr=dst; sramWriteData=captured word.
  - Then src+=WORD_BYTES, dst+=WORD_BYTES, count-=1.
  - Next state: DONE if count reaches 0, else D2S_RD.
- S2D_RD:
  - sramAddr=src; sramReadData captured at the edge; go to S2D_WR.
- S2D_WR:
  - dramWriteReq=1, dramAddr=dst, dramWriteData=captured word; held until dramAck.
  - On ack: increment both addresses, decrement count; DONE if 0, else S2D_RD.
- DONE: valid=1 for one cycle, stall=0; next state IDLE.
- Output decode:
  - stall is registered: high in every state except IDLE and DONE, so it rises the cycle after the command is accepted.
  - sramOwn = stall.
  - dramReadReq and dramWriteReq are never both high.
  - sramWriteEnable is only high in D2S_WR.
- Latency with zero-wait DRAM (ack in the first request cycle): N words → 2N stall cycles, then a 1-cycle valid pulse. Each DRAM wait cycle adds 1.
- Width 0: no memory access; valid is high the cycle after acceptance; stall never rises.
- Address arithmetic is 32-bit modulo (wraps at 0xFFFFFFFC→0x00000000). Count is unsigned; max 1023 words.
- dramAck outside a request state is ignored.

Test Plan:
- Reset mid-stream:
  - Assert reset during D2S_RD of a 4-word transfer → all outputs 0 immediately.
  - No valid pulse.
  - Next cmd=01 src=0x40 dst=0x0 width=1 completes normally.
- d2s, zero-wait DRAM:
  - cmd=01 src=0x100 dst=0x20 width=3; DRAM words at 0x100/0x104/0x108 = 0xA,0xB,0xC; dramAck tied to dramReadReq.
  - SRAM writes 0xA@0x20, 0xB@0x24, 0xC@0x28.
  - stall high exactly 6 cycles; valid pulse on the 7th cycle after acceptance.
- s2d, DRAM waits 2 cycles per write:
  - cmd=10 src=0x0 dst=0x200 width=2; SRAM holds 0x11,0x22.
  - DRAM writes 0x11@0x200, 0x22@0x204.
  - Request and data are stable through the wait cycles; stall high for 8 cycles.
- width=0 and cmd=11:
  - cmd=01 width=0 → valid high the next cycle, stall stays 0, no req/WE.
  - cmd=11 → no response at all.
- Command during busy:
  - Drive cmd=10 while a d2s transfer is in progress → ignored; the original transfer completes unchanged.
- Wrap-around:
  - cmd=01 src=0xFFFFFFFC dst=0x0 width=2 → DRAM reads at 0xFFFFFFFC then 0x00000000.
